// File: rtl/mpy_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mpy_pkg                                                                |
// | Shared width limits and the partial-product row builder used by the    |
// | pipelined multiplier stages.                                           |
// | Ports: none (package).                                                 |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package mpy_pkg;

  localparam int MPY_W_MIN = 2;
  localparam int MPY_W_MAX = 32;
  localparam int MPY_P_MAX = 2 * MPY_W_MAX;

  // Builds one partial-product row at full 2*MPY_W_MAX width; callers keep
  // the low 2W bits, which is exact because all arithmetic is modulo 2^(2W).
  // w is the live operand width used for sign extension.
  function automatic logic [MPY_P_MAX-1:0] mpy_row(
    input logic [MPY_W_MAX-1:0] a,
    input logic                 b_bit,
    input int unsigned          k,
    input logic                 tc,
    input logic                 last,
    input int unsigned          w
  );
    logic [MPY_P_MAX-1:0] mask;
    logic [MPY_P_MAX-1:0] ext;
    logic [MPY_P_MAX-1:0] row;
    logic                 sgn;
    mask = (MPY_P_MAX'(1) << w) - MPY_P_MAX'(1);
    ext  = MPY_P_MAX'(a) & mask;
    sgn  = |(MPY_P_MAX'(a) & (MPY_P_MAX'(1) << (w - 1)));
    if (tc && sgn) begin
      ext = ext | ~mask;
    end
    row = b_bit ? (ext << k) : '0;
    // The multiplier's MSB carries weight -2^(W-1) in two's complement,
    // so its row is subtracted rather than added.
    if (tc && last) begin
      row = ~row + MPY_P_MAX'(1);
    end
    return row;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpy_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mpy_stage                                                              |
// | One pipeline stage: adds row K of the shift-and-add product to the     |
// | incoming accumulator and registers valid/a/b/tc/acc.                   |
// | Ports: clk, rst_n (sync, active-low), en (global hold when 0),         |
// |        valid_i/a_i/b_i/tc_i/acc_i from upstream,                       |
// |        valid_o/a_o/b_o/tc_o/acc_o registered towards downstream.       |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module mpy_stage
  import mpy_pkg::*;
#(
  parameter int W = 8,
  parameter int K = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           valid_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           tc_i,
  input  logic [2*W-1:0] acc_i,
  output logic           valid_o,
  output logic [W-1:0]   a_o,
  output logic [W-1:0]   b_o,
  output logic           tc_o,
  output logic [2*W-1:0] acc_o
);

  localparam int P = 2 * W;

  logic           valid_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           tc_q;
  logic [P-1:0]   acc_q;
  logic [P-1:0]   row_w;
  logic [P-1:0]   acc_d;

  assign row_w = P'(mpy_row(MPY_W_MAX'(a_i), b_i[K], K, tc_i, (K == W - 1), W));

  always_comb begin
    acc_d = acc_i + row_w;
  end

  // Data registers are cleared too so the product output never shows X.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tc_q    <= 1'b0;
      acc_q   <= '0;
    end else if (en) begin
      valid_q <= valid_i;
      a_q     <= a_i;
      b_q     <= b_i;
      tc_q    <= tc_i;
      acc_q   <= acc_d;
    end
  end

  assign valid_o = valid_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign tc_o    = tc_q;
  assign acc_o   = acc_q;

endmodule
`default_nettype wire

// File: rtl/signed_mpy_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | signed_mpy_pipe                                                        |
// | W-stage pipelined WxW multiplier, signed or unsigned per transaction,  |
// | exact 2W-bit product after W cycles, valid/ready on both sides.        |
// | Ports: clk, rst_n (sync, active-low),                                  |
// |        in_valid/in_ready/in_a/in_b/in_tc   - operand handshake,        |
// |        out_valid/out_ready/out_product/out_tc - result handshake.      |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module signed_mpy_pipe
  import mpy_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_tc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_product,
  output logic           out_tc
);

  // Index 0 is the pipeline input, index k+1 the output of stage k.
  logic                  en_w;
  logic [W:0]            valid_w;
  logic [W:0]            tc_w;
  logic [W:0][W-1:0]     a_w;
  logic [W:0][W-1:0]     b_w;
  logic [W:0][2*W-1:0]   acc_w;
  logic                  unused_w;

  // The whole pipe moves or holds as one; bubbles advance like data.
  assign en_w     = !out_valid || out_ready;
  assign in_ready = en_w;

  assign valid_w[0] = in_valid;
  assign a_w[0]     = in_a;
  assign b_w[0]     = in_b;
  assign tc_w[0]    = in_tc;
  assign acc_w[0]   = '0;

  generate
    for (genvar k = 0; k < W; k++) begin : g_stage
      mpy_stage #(
        .W (W),
        .K (k)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en_w),
        .valid_i (valid_w[k]),
        .a_i     (a_w[k]),
        .b_i     (b_w[k]),
        .tc_i    (tc_w[k]),
        .acc_i   (acc_w[k]),
        .valid_o (valid_w[k+1]),
        .a_o     (a_w[k+1]),
        .b_o     (b_w[k+1]),
        .tc_o    (tc_w[k+1]),
        .acc_o   (acc_w[k+1])
      );
    end
  endgenerate

  assign out_valid   = valid_w[W];
  assign out_product = acc_w[W];
  assign out_tc      = tc_w[W];

  // Operands leaving the last stage have no consumer.
  assign unused_w = ^{a_w[W], b_w[W]};

endmodule
`default_nettype wire

// File: tb/tb_signed_mpy_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_signed_mpy_pipe                                                     |
// | Directed bench for signed_mpy_pipe at W=8, W=16 and W=3.               |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_signed_mpy_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  // W=8 instance
  logic        v8, tc8, ordy8, irdy8, ov8, otc8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  // W=16 instance
  logic        v16, tc16, ordy16, irdy16, ov16, otc16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;
  // W=3 instance
  logic        v3, tc3, ordy3, irdy3, ov3, otc3;
  logic [2:0]  a3, b3;
  logic [5:0]  prod3;

  signed_mpy_pipe #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(irdy8), .in_a(a8), .in_b(b8),
    .in_tc(tc8), .out_valid(ov8), .out_ready(ordy8), .out_product(prod8), .out_tc(otc8));
  signed_mpy_pipe #(.W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(irdy16), .in_a(a16), .in_b(b16),
    .in_tc(tc16), .out_valid(ov16), .out_ready(ordy16), .out_product(prod16), .out_tc(otc16));
  signed_mpy_pipe #(.W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(irdy3), .in_a(a3), .in_b(b3),
    .in_tc(tc3), .out_valid(ov3), .out_ready(ordy3), .out_product(prod3), .out_tc(otc3));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    if (obs !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, req);
    end
  endtask

  // Reference: widen both operands to 64 bits (sign- or zero-extended) and
  // multiply; the low 2w bits are the exact product.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic tc, input int w);
    logic [63:0] m_in, sa, sb, m_out;
    m_in = (64'd1 << w) - 64'd1;
    sa   = {32'd0, a} & m_in;
    sb   = {32'd0, b} & m_in;
    if (tc && (((sa >> (w - 1)) & 64'd1) != 64'd0)) sa = sa | ~m_in;
    if (tc && (((sb >> (w - 1)) & 64'd1) != 64'd0)) sb = sb | ~m_in;
    m_out = (64'd1 << (2 * w)) - 64'd1;
    return (sa * sb) & m_out;
  endfunction

  // Expected results of the W=8 instance, {tc, product}, in acceptance order.
  logic [16:0] q8[$];

  // Called at a negedge: drive inputs, score the transfers of the coming
  // posedge, then advance to the next negedge.
  task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic tc, input logic ordy);
    logic [16:0] e;
    logic [63:0] m;
    v8 = v; a8 = a; b8 = b; tc8 = tc; ordy8 = ordy;
    #1;
    if (ov8 && ordy) begin
      if (q8.size() == 0) begin
        check_eq("d8_spurious_out", 64'(ov8), 64'd0);
      end else begin
        e = q8.pop_front();
        check_eq("d8_prod", 64'(prod8), 64'(e[15:0]));
        check_eq("d8_tc", 64'(otc8), 64'(e[16]));
      end
    end
    if (v && irdy8) begin
      m = ref_mul(32'(a), 32'(b), tc, 8);
      q8.push_back({tc, m[15:0]});
    end
    @(negedge clk);
  endtask

  // Single transaction on an empty pipe: latency, hand-computed product, tc.
  task automatic direct8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic tc, input logic [15:0] req);
    int n;
    step8(1'b1, a, b, tc, 1'b1);
    n = 0;
    while (!ov8 && n < 20) begin
      step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      n++;
    end
    check_eq({tag, "_latency"}, 64'(n), 64'd7);
    check_eq({tag, "_prod"}, 64'(prod8), 64'(req));
    check_eq({tag, "_tc"}, 64'(otc8), 64'(tc));
    step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  logic [15:0] va16 [12];
  logic [15:0] vb16 [12];
  logic        vt16 [12];

  // W=3 vectors with hand-computed 6-bit products.
  logic [2:0] va3 [10] = '{3'd4, 3'd7, 3'd7, 3'd4, 3'd3, 3'd0, 3'd4, 3'd4, 3'd5, 3'd2};
  logic [2:0] vb3 [10] = '{3'd4, 3'd7, 3'd7, 3'd3, 3'd3, 3'd4, 3'd7, 3'd7, 3'd6, 3'd4};
  logic       vt3 [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [5:0] vp3 [10] = '{6'h10, 6'h31, 6'h01, 6'h34, 6'h09, 6'h00, 6'h04, 6'h1C, 6'h06, 6'h38};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hold_p;
    logic        hold_t;
    logic [63:0] m;
    int          idx;

    rst_n = 1'b0;
    v8 = 0;  a8 = '0;  b8 = '0;  tc8 = 0;  ordy8 = 1;
    v16 = 0; a16 = '0; b16 = '0; tc16 = 0; ordy16 = 1;
    v3 = 0;  a3 = '0;  b3 = '0;  tc3 = 0;  ordy3 = 1;

    va16 = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 16'h7FFF, 16'hFFFF,
             16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    vb16 = '{16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000,
             16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    vt16 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 7; i < 12; i++) begin
      va16[i] = 16'($urandom);
      vb16[i] = 16'($urandom);
      vt16[i] = 1'($urandom);
    end

    repeat (2) @(negedge clk);
    check_eq("rst_out_valid8", 64'(ov8), 64'd0);
    check_eq("rst_prod8", 64'(prod8), 64'd0);
    check_eq("rst_tc8", 64'(otc8), 64'd0);
    check_eq("rst_in_ready8", 64'(irdy8), 64'd1);
    check_eq("rst_prod16", 64'(prod16), 64'd0);
    check_eq("rst_in_ready16", 64'(irdy16), 64'd1);
    check_eq("rst_prod3", 64'(prod3), 64'd0);
    check_eq("rst_in_ready3", 64'(irdy3), 64'd1);
    rst_n = 1'b1;

    // Directed W=8 corner products.
    direct8("minmin_s", 8'h80, 8'h80, 1'b1, 16'h4000);
    direct8("ffff_u",   8'hFF, 8'hFF, 1'b0, 16'hFE01);
    direct8("ffff_s",   8'hFF, 8'hFF, 1'b1, 16'h0001);
    direct8("ff01_s",   8'hFF, 8'h01, 1'b1, 16'hFFFF);

    // Back-to-back stream: every result must leave within 8 cycles of the
    // last accept, which is only possible at one result per cycle.
    for (int i = 0; i < 20; i++) begin
      step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end
    repeat (8) step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check_eq("stream_all_out", 64'(q8.size()), 64'd0);
    check_eq("stream_idle", 64'(ov8), 64'd0);

    // Backpressure with a full pipe.
    for (int i = 0; i < 10; i++) begin
      step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      hold_p = prod8;
      hold_t = otc8;
      step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      check_eq("bp_in_ready", 64'(irdy8), 64'd0);
      check_eq("bp_out_valid", 64'(ov8), 64'd1);
      check_eq("bp_prod_hold", 64'(prod8), 64'(hold_p));
      check_eq("bp_tc_hold", 64'(otc8), 64'(hold_t));
    end
    for (int i = 0; i < 5; i++) begin
      step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end
    repeat (10) step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check_eq("bp_all_out", 64'(q8.size()), 64'd0);

    // Reset with four transactions in flight.
    for (int i = 0; i < 4; i++) begin
      step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end
    v8 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q8.delete();
    check_eq("midrst_out_valid", 64'(ov8), 64'd0);
    check_eq("midrst_prod", 64'(prod8), 64'd0);
    check_eq("midrst_in_ready", 64'(irdy8), 64'd1);
    repeat (12) step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check_eq("midrst_none_out", 64'(ov8), 64'd0);

    // W=16: result of input step i must appear exactly after step i+15.
    for (int s = 0; s < 12 + 16; s++) begin
      v16 = (s < 12);
      if (s < 12) begin
        a16 = va16[s]; b16 = vb16[s]; tc16 = vt16[s];
      end
      @(negedge clk);
      idx = s - 15;
      if (idx >= 0 && idx < 12) begin
        m = ref_mul(32'(va16[idx]), 32'(vb16[idx]), vt16[idx], 16);
        check_eq("w16_valid", 64'(ov16), 64'd1);
        check_eq("w16_prod", 64'(prod16), m);
        check_eq("w16_tc", 64'(otc16), 64'(vt16[idx]));
      end else begin
        check_eq("w16_idle", 64'(ov16), 64'd0);
      end
    end
    v16 = 1'b0;

    // W=3 against the hand-computed table, latency 3.
    for (int s = 0; s < 10 + 3; s++) begin
      v3 = (s < 10);
      if (s < 10) begin
        a3 = va3[s]; b3 = vb3[s]; tc3 = vt3[s];
      end
      @(negedge clk);
      idx = s - 2;
      if (idx >= 0 && idx < 10) begin
        check_eq("w3_valid", 64'(ov3), 64'd1);
        check_eq("w3_prod", 64'(prod3), 64'(vp3[idx]));
        check_eq("w3_tc", 64'(otc3), 64'(vt3[idx]));
      end else begin
        check_eq("w3_idle", 64'(ov3), 64'd0);
      end
    end
    v3 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
